// File: rtl/phased_cache_nway.sv
// Phased N-way set-associative cache: tags compared in one cycle, data accessed in the next.
// Misses write back a dirty victim, then allocate (read or write). Replacement is FIFO or LRU via per-line ages.
module phased_cache_nway #(
   parameter  int WAYS   = 8,
   parameter  int SETS   = 4,
   parameter  int TAG_W  = 26,
   parameter  int LINE_B = 16,
   parameter  int REPL   = 0,
   localparam int WAY_W  = $clog2(WAYS),
   localparam int IDX_W  = $clog2(SETS),
   localparam int OFF_W  = $clog2(LINE_B),
   localparam int LINE_W = 8 * LINE_B
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_rw,
   input  logic [TAG_W-1:0]       req_tag,
   input  logic [IDX_W-1:0]       req_index,
   input  logic [OFF_W-1:0]       req_offset,
   input  logic [7:0]             req_wbyte,
   output logic                   rsp_valid,
   output logic                   rsp_hit,
   output logic [7:0]             rsp_rdata,
   output logic                   mem_req_valid,
   input  logic                   mem_req_ready,
   output logic                   mem_req_we,
   output logic [TAG_W+IDX_W-1:0] mem_req_addr,
   output logic [LINE_W-1:0]      mem_wdata,
   input  logic                   mem_rsp_valid,
   input  logic [LINE_W-1:0]      mem_rsp_data
);

   typedef enum logic [2:0] {IDLE, TAG, DATA, WB, FILL_REQ, FILL_WAIT, RESP} state_t;

   state_t             state_q, state_d;
   logic               rw_q, rw_d;
   logic [TAG_W-1:0]   rtag_q, rtag_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [OFF_W-1:0]   off_q, off_d;
   logic [7:0]         wbyte_q, wbyte_d;
   logic [WAY_W-1:0]   way_q, way_d;

   logic               valid_q [SETS][WAYS];
   logic               valid_d [SETS][WAYS];
   logic               dirty_q [SETS][WAYS];
   logic               dirty_d [SETS][WAYS];
   logic [WAY_W-1:0]   age_q   [SETS][WAYS];
   logic [WAY_W-1:0]   age_d   [SETS][WAYS];
   logic [TAG_W-1:0]   tags_q  [SETS][WAYS];
   logic [TAG_W-1:0]   tags_d  [SETS][WAYS];
   logic [LINE_W-1:0]  data_q  [SETS][WAYS];
   logic [LINE_W-1:0]  data_d  [SETS][WAYS];

   logic [WAYS-1:0]    match;
   logic               hit;
   logic               any_invalid;
   logic [WAY_W-1:0]   hit_way;
   logic [WAY_W-1:0]   victim;
   logic [LINE_W-1:0]  line;
   logic               touch;
   logic [OFF_W+2:0]   bsel;

   assign bsel = {off_q, 3'b000};

   for (genvar gi = 0; gi < WAYS; gi++) begin : g_cmp
      assign match[gi] = valid_q[idx_q][gi] && (tags_q[idx_q][gi] == rtag_q);
   end
   assign hit = |match;

   // Descending scans so the lowest qualifying way wins.
   always_comb begin
      hit_way     = '0;
      victim      = '0;
      any_invalid = 1'b0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (match[w]) hit_way = WAY_W'(w);
         if (!valid_q[idx_q][w]) begin
            victim      = WAY_W'(w);
            any_invalid = 1'b1;
         end
      end
      if (!any_invalid) begin
         for (int w = WAYS - 1; w >= 0; w--) begin
            if (age_q[idx_q][w] == '0) victim = WAY_W'(w);
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      rw_d          = rw_q;
      rtag_d        = rtag_q;
      idx_d         = idx_q;
      off_d         = off_q;
      wbyte_d       = wbyte_q;
      way_d         = way_q;
      valid_d       = valid_q;
      dirty_d       = dirty_q;
      age_d         = age_q;
      tags_d        = tags_q;
      data_d        = data_q;
      line          = data_q[idx_q][way_q];
      touch         = 1'b0;
      req_ready     = 1'b0;
      rsp_valid     = 1'b0;
      rsp_hit       = 1'b0;
      rsp_rdata     = 8'h00;
      mem_req_valid = 1'b0;
      mem_req_we    = 1'b0;
      mem_req_addr  = '0;
      mem_wdata     = '0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               rw_d    = req_rw;
               rtag_d  = req_tag;
               idx_d   = req_index;
               off_d   = req_offset;
               wbyte_d = req_wbyte;
               state_d = TAG;
            end
         end
         TAG: begin
            way_d = hit ? hit_way : victim;
            if (hit) state_d = DATA;
            else if (valid_q[idx_q][victim] && dirty_q[idx_q][victim]) state_d = WB;
            else state_d = FILL_REQ;
         end
         DATA: begin
            rsp_valid = 1'b1;
            rsp_hit   = 1'b1;
            if (rw_q) begin
               line[bsel +: 8]       = wbyte_q;
               data_d[idx_q][way_q]  = line;
               dirty_d[idx_q][way_q] = 1'b1;
            end else begin
               rsp_rdata = line[bsel +: 8];
            end
            touch   = (REPL == 1);
            state_d = IDLE;
         end
         WB: begin
            mem_req_valid = 1'b1;
            mem_req_we    = 1'b1;
            mem_req_addr  = {tags_q[idx_q][way_q], idx_q};
            mem_wdata     = data_q[idx_q][way_q];
            if (mem_req_ready) state_d = FILL_REQ;
         end
         FILL_REQ: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = {rtag_q, idx_q};
            if (mem_req_ready) state_d = FILL_WAIT;
         end
         FILL_WAIT: begin
            if (mem_rsp_valid) begin
               line = mem_rsp_data;
               if (rw_q) line[bsel +: 8] = wbyte_q;
               data_d[idx_q][way_q]  = line;
               tags_d[idx_q][way_q]  = rtag_q;
               valid_d[idx_q][way_q] = 1'b1;
               dirty_d[idx_q][way_q] = rw_q;
               touch                 = 1'b1;
               state_d               = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            rsp_rdata = rw_q ? 8'h00 : line[bsel +: 8];
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Promote the touched way to youngest; ages above it slide down, keeping a permutation.
      if (touch) begin
         for (int w = 0; w < WAYS; w++) begin
            if (age_q[idx_q][w] > age_q[idx_q][way_q]) age_d[idx_q][w] = age_q[idx_q][w] - WAY_W'(1);
         end
         age_d[idx_q][way_q] = WAY_W'(WAYS - 1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               valid_q[s][w] <= 1'b0;
               dirty_q[s][w] <= 1'b0;
               age_q[s][w]   <= WAY_W'(w);
            end
         end
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         dirty_q <= dirty_d;
         age_q   <= age_d;
      end
   end

   // Payload state needs no reset: it is only observed through valid lines and the FSM.
   always_ff @(posedge clk) begin
      rw_q    <= rw_d;
      rtag_q  <= rtag_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      wbyte_q <= wbyte_d;
      way_q   <= way_d;
      tags_q  <= tags_d;
      data_q  <= data_d;
   end

endmodule

// File: tb/tb_phased_cache_nway.sv
// Directed bench: instance 0 uses FIFO replacement, instance 1 LRU; a small responder serves memory.
module tb_phased_cache_nway;

   logic         clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n         [2];
   logic         req_valid     [2];
   logic         req_ready     [2];
   logic         req_rw        [2];
   logic [25:0]  req_tag       [2];
   logic [1:0]   req_index     [2];
   logic [3:0]   req_offset    [2];
   logic [7:0]   req_wbyte     [2];
   logic         rsp_valid     [2];
   logic         rsp_hit       [2];
   logic [7:0]   rsp_rdata     [2];
   logic         mem_req_valid [2];
   logic         mem_req_ready [2];
   logic         mem_req_we    [2];
   logic [27:0]  mem_req_addr  [2];
   logic [127:0] mem_wdata     [2];
   logic         mem_rsp_valid [2];
   logic [127:0] mem_rsp_data  [2];

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      phased_cache_nway #(.WAYS(8), .SETS(4), .TAG_W(26), .LINE_B(16), .REPL(gi)) dut (
         .clk           (clk),
         .reset         (rst_n[gi]),
         .req_valid     (req_valid[gi]),
         .req_ready     (req_ready[gi]),
         .req_rw        (req_rw[gi]),
         .req_tag       (req_tag[gi]),
         .req_index     (req_index[gi]),
         .req_offset    (req_offset[gi]),
         .req_wbyte     (req_wbyte[gi]),
         .rsp_valid     (rsp_valid[gi]),
         .rsp_hit       (rsp_hit[gi]),
         .rsp_rdata     (rsp_rdata[gi]),
         .mem_req_valid (mem_req_valid[gi]),
         .mem_req_ready (mem_req_ready[gi]),
         .mem_req_we    (mem_req_we[gi]),
         .mem_req_addr  (mem_req_addr[gi]),
         .mem_wdata     (mem_wdata[gi]),
         .mem_rsp_valid (mem_rsp_valid[gi]),
         .mem_rsp_data  (mem_rsp_data[gi])
      );
   end

   int           n_checks = 0;
   int           n_fail   = 0;
   logic [127:0] fill_line;
   logic         r_got, r_hit, r_after;
   logic [7:0]   r_data;
   int           r_cyc, n_wb, n_fill;
   logic [27:0]  wb_addr, fill_addr;
   logic [127:0] wb_data;

   task automatic check_eq(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [127:0] pat(input logic [25:0] t);
      logic [127:0] l;
      for (int k = 0; k < 16; k++) l[8*k +: 8] = {t[3:0], 4'(k)} ^ 8'h30;
      return l;
   endfunction

   function automatic logic [7:0] byte_of(input logic [127:0] l, input int off);
      return l[8*off +: 8];
   endfunction

   // One request on unit u; serves write-back/fill traffic and captures the response.
   task automatic txn(input int u, input logic rw, input logic [25:0] tg, input logic [1:0] ix,
                      input logic [3:0] off, input logic [7:0] wb, input int stall);
      int           stall_left;
      logic         fill_pend;
      logic [27:0]  ref_addr;
      logic         ref_we;
      logic [127:0] ref_wd;
      r_got = 1'b0; r_hit = 1'b0; r_data = 8'h00; r_after = 1'b0; r_cyc = 0;
      n_wb = 0; n_fill = 0; wb_addr = '0; wb_data = '0; fill_addr = '0;
      fill_pend = 1'b0; stall_left = stall;
      ref_addr = '0; ref_we = 1'b0; ref_wd = '0;
      @(negedge clk);
      req_rw[u] = rw; req_tag[u] = tg; req_index[u] = ix; req_offset[u] = off; req_wbyte[u] = wb;
      req_valid[u] = 1'b1;
      check_eq("accept.ready", 128'(req_ready[u]), 128'd1);
      @(posedge clk);
      #1 req_valid[u] = 1'b0;
      for (int cyc = 1; cyc <= 40 && !r_got; cyc++) begin
         @(negedge clk);
         mem_req_ready[u] = 1'b0;
         mem_rsp_valid[u] = 1'b0;
         if (fill_pend) begin
            mem_rsp_valid[u] = 1'b1;
            mem_rsp_data[u]  = fill_line;
            fill_pend        = 1'b0;
         end
         if (rsp_valid[u]) begin
            r_got = 1'b1; r_hit = rsp_hit[u]; r_data = rsp_rdata[u]; r_cyc = cyc;
         end
         if (mem_req_valid[u]) begin
            if (stall_left > 0) begin
               if (stall_left == stall) begin
                  ref_addr = mem_req_addr[u]; ref_we = mem_req_we[u]; ref_wd = mem_wdata[u];
               end else begin
                  check_eq("stall.addr_hold", 128'(mem_req_addr[u]), 128'(ref_addr));
                  check_eq("stall.we_hold", 128'(mem_req_we[u]), 128'(ref_we));
                  check_eq("stall.wdata_hold", mem_wdata[u], ref_wd);
               end
               check_eq("stall.addr", 128'(mem_req_addr[u]), 128'({tg, ix}));
               check_eq("stall.req_ready", 128'(req_ready[u]), 128'd0);
               check_eq("stall.rsp", 128'(rsp_valid[u]), 128'd0);
               req_valid[u] = 1'b1;
               stall_left--;
            end else begin
               req_valid[u]     = 1'b0;
               mem_req_ready[u] = 1'b1;
               if (mem_req_we[u]) begin
                  n_wb++; wb_addr = mem_req_addr[u]; wb_data = mem_wdata[u];
               end else begin
                  n_fill++; fill_addr = mem_req_addr[u]; fill_pend = 1'b1;
               end
            end
         end
      end
      req_valid[u] = 1'b0; mem_req_ready[u] = 1'b0; mem_rsp_valid[u] = 1'b0;
      @(negedge clk);
      r_after = rsp_valid[u];
      $display("txn u%0d %s tag=%0h idx=%0d off=%0d rsp=%0b hit=%0b rdata=%02h wb=%0d fill=%0d cyc=%0d",
               u, rw ? "WR" : "RD", tg, ix, off, r_got, r_hit, r_data, n_wb, n_fill, r_cyc);
   endtask

   task automatic chk_rsp(input string nm, input logic e_hit, input logic [7:0] e_data,
                          input int e_wb, input int e_fill);
      check_eq({nm, ".rsp"}, 128'(r_got), 128'd1);
      check_eq({nm, ".hit"}, 128'(r_hit), 128'(e_hit));
      check_eq({nm, ".rdata"}, 128'(r_data), 128'(e_data));
      check_eq({nm, ".wb"}, 128'(n_wb), 128'(e_wb));
      check_eq({nm, ".fill"}, 128'(n_fill), 128'(e_fill));
      check_eq({nm, ".pulse"}, 128'(r_after), 128'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] l;
      logic         seen;
      for (int u = 0; u < 2; u++) begin
         rst_n[u] = 1'b0; req_valid[u] = 1'b0; req_rw[u] = 1'b0; req_tag[u] = '0;
         req_index[u] = '0; req_offset[u] = '0; req_wbyte[u] = '0;
         mem_req_ready[u] = 1'b0; mem_rsp_valid[u] = 1'b0; mem_rsp_data[u] = '0;
      end
      fill_line = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n[0] = 1'b1; rst_n[1] = 1'b1;
      check_eq("rst.req_ready", 128'(req_ready[0]), 128'd1);
      check_eq("rst.rsp_valid", 128'(rsp_valid[0]), 128'd0);
      check_eq("rst.rsp_hit", 128'(rsp_hit[0]), 128'd0);
      check_eq("rst.rsp_rdata", 128'(rsp_rdata[0]), 128'd0);
      check_eq("rst.mem_req_valid", 128'(mem_req_valid[0]), 128'd0);
      check_eq("rst.mem_req_we", 128'(mem_req_we[0]), 128'd0);
      check_eq("rst.mem_req_addr", 128'(mem_req_addr[0]), 128'd0);
      check_eq("rst.mem_wdata", mem_wdata[0], 128'd0);
      check_eq("rst.req_ready_lru", 128'(req_ready[1]), 128'd1);

      // Cold read miss, then hit with two-cycle latency
      l = pat(26'h123); l[24 +: 8] = 8'hA5; fill_line = l;
      txn(0, 1'b0, 26'h123, 2'd1, 4'd3, 8'h00, 0);
      chk_rsp("cold_rd", 1'b0, 8'hA5, 0, 1);
      check_eq("cold_rd.addr", 128'(fill_addr), 128'({26'h123, 2'b01}));
      txn(0, 1'b0, 26'h123, 2'd1, 4'd3, 8'h00, 0);
      chk_rsp("hit_rd", 1'b1, 8'hA5, 0, 0);
      check_eq("hit_rd.latency", 128'(r_cyc), 128'd2);

      // Write hit and read-back
      txn(0, 1'b1, 26'h123, 2'd1, 4'd0, 8'h3C, 0);
      chk_rsp("wr_hit", 1'b1, 8'h00, 0, 0);
      txn(0, 1'b0, 26'h123, 2'd1, 4'd0, 8'h00, 0);
      chk_rsp("rd_after_wr", 1'b1, 8'h3C, 0, 0);
      txn(0, 1'b0, 26'h123, 2'd1, 4'd3, 8'h00, 0);
      chk_rsp("rd_other_byte", 1'b1, 8'hA5, 0, 0);

      // FIFO: fill set 2, dirty tag 0, miss tag 8 -> write-back of tag 0's line
      for (int t = 0; t < 8; t++) begin
         fill_line = pat(26'(t));
         txn(0, 1'b0, 26'(t), 2'd2, 4'(t), 8'h00, 0);
         chk_rsp("fifo_fill", 1'b0, byte_of(pat(26'(t)), t), 0, 1);
      end
      txn(0, 1'b1, 26'd0, 2'd2, 4'd5, 8'hEE, 0);
      chk_rsp("fifo_wr", 1'b1, 8'h00, 0, 0);
      l = pat(26'd0); l[40 +: 8] = 8'hEE;
      fill_line = pat(26'd8);
      txn(0, 1'b0, 26'd8, 2'd2, 4'd2, 8'h00, 0);
      chk_rsp("fifo_evict", 1'b0, byte_of(pat(26'd8), 2), 1, 1);
      check_eq("fifo_evict.wb_addr", 128'(wb_addr), 128'({26'd0, 2'b10}));
      check_eq("fifo_evict.wb_data", wb_data, l);
      check_eq("fifo_evict.fill_addr", 128'(fill_addr), 128'({26'd8, 2'b10}));
      txn(0, 1'b0, 26'd8, 2'd2, 4'd9, 8'h00, 0);
      chk_rsp("fifo_hit8", 1'b1, byte_of(pat(26'd8), 9), 0, 0);
      txn(0, 1'b0, 26'd1, 2'd2, 4'd1, 8'h00, 0);
      chk_rsp("fifo_hit1", 1'b1, byte_of(pat(26'd1), 1), 0, 0);
      fill_line = pat(26'd0);
      txn(0, 1'b0, 26'd0, 2'd2, 4'd5, 8'h00, 0);
      chk_rsp("fifo_refill0", 1'b0, byte_of(pat(26'd0), 5), 0, 1);

      // LRU: fill set 0, touch tag 0, miss tag 8 evicts tag 1 cleanly
      for (int t = 0; t < 8; t++) begin
         fill_line = pat(26'(t));
         txn(1, 1'b0, 26'(t), 2'd0, 4'd15, 8'h00, 0);
         chk_rsp("lru_fill", 1'b0, byte_of(pat(26'(t)), 15), 0, 1);
      end
      txn(1, 1'b0, 26'd0, 2'd0, 4'd4, 8'h00, 0);
      chk_rsp("lru_hit0", 1'b1, byte_of(pat(26'd0), 4), 0, 0);
      fill_line = pat(26'd8);
      txn(1, 1'b0, 26'd8, 2'd0, 4'd6, 8'h00, 0);
      chk_rsp("lru_miss8", 1'b0, byte_of(pat(26'd8), 6), 0, 1);
      fill_line = pat(26'd1);
      txn(1, 1'b0, 26'd1, 2'd0, 4'd2, 8'h00, 0);
      chk_rsp("lru_tag1_gone", 1'b0, byte_of(pat(26'd1), 2), 0, 1);
      txn(1, 1'b0, 26'd0, 2'd0, 4'd7, 8'h00, 0);
      chk_rsp("lru_tag0_kept", 1'b1, byte_of(pat(26'd0), 7), 0, 0);
      txn(1, 1'b0, 26'd8, 2'd0, 4'd0, 8'h00, 0);
      chk_rsp("lru_tag8_kept", 1'b1, byte_of(pat(26'd8), 0), 0, 0);

      // Memory back-pressure for five cycles on a fill
      fill_line = pat(26'h55);
      txn(0, 1'b0, 26'h55, 2'd3, 4'd7, 8'h00, 5);
      chk_rsp("stall", 1'b0, byte_of(pat(26'h55), 7), 0, 1);

      // Reset during FILL_WAIT abandons the miss
      fill_line = pat(26'h77);
      @(negedge clk);
      req_rw[0] = 1'b0; req_tag[0] = 26'h77; req_index[0] = 2'd1; req_offset[0] = 4'd4;
      req_valid[0] = 1'b1;
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (mem_req_valid[0]) seen = 1'b1;
      end
      check_eq("rst_mid.fill_req", 128'(seen), 128'd1);
      check_eq("rst_mid.fill_addr", 128'(mem_req_addr[0]), 128'({26'h77, 2'b01}));
      mem_req_ready[0] = 1'b1;
      @(negedge clk);
      mem_req_ready[0] = 1'b0;
      rst_n[0] = 1'b0;
      @(negedge clk);
      rst_n[0] = 1'b1;
      check_eq("rst_mid.req_ready", 128'(req_ready[0]), 128'd1);
      check_eq("rst_mid.mem_req_valid", 128'(mem_req_valid[0]), 128'd0);
      check_eq("rst_mid.rsp", 128'(rsp_valid[0]), 128'd0);
      mem_rsp_valid[0] = 1'b1;
      mem_rsp_data[0]  = fill_line;
      @(negedge clk);
      mem_rsp_valid[0] = 1'b0;
      check_eq("rst_mid.late_rsp", 128'(rsp_valid[0]), 128'd0);
      check_eq("rst_mid.late_ready", 128'(req_ready[0]), 128'd1);
      @(negedge clk);
      check_eq("rst_mid.late_rsp2", 128'(rsp_valid[0]), 128'd0);
      txn(0, 1'b0, 26'h77, 2'd1, 4'd4, 8'h00, 0);
      chk_rsp("rst_mid.reread", 1'b0, byte_of(pat(26'h77), 4), 0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/phased_cache_nway.md
PHASED_CACHE_NWAY -- requirements
Module: phased_cache_nway

Interface
REQ-001 SHALL have parameter WAYS, default 8, associativity (power of 2, 2..16); WAY_W = log2(WAYS).
REQ-002 SHALL have parameter SETS, default 4, set count (power of 2, >=2); IDX_W = log2(SETS).
REQ-003 SHALL have parameter TAG_W, default 26, tag width.
REQ-004 SHALL have parameter LINE_B, default 16, bytes per line (power of 2); OFF_W = log2(LINE_B).
REQ-005 SHALL have parameter REPL, default 0, replacement mode: 0 = FIFO, 1 = LRU.
REQ-006 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-008 SHALL have ports req_valid in 1 and req_ready out 1, request handshake.
REQ-009 SHALL have ports req_rw in 1 (0 = read, 1 = write), req_tag in TAG_W, req_index in IDX_W, req_offset in OFF_W, and req_wbyte in 8 (write byte).
REQ-010 SHALL have ports rsp_valid out 1 (one-cycle pulse), rsp_hit out 1, and rsp_rdata out 8.
REQ-011 SHALL have ports mem_req_valid out 1, mem_req_ready in 1, mem_req_we out 1 (1 = writeback, 0 = fill), mem_req_addr out TAG_W+IDX_W ({tag,index}), and mem_wdata out 8*LINE_B.
REQ-012 SHALL have ports mem_rsp_valid in 1 and mem_rsp_data in 8*LINE_B (fill line; byte k at bits [8k+7:8k]).

Function
REQ-013 SHALL run an FSM with states IDLE, TAG, DATA, WB, FILL_REQ, FILL_WAIT and RESP; req_ready = 1 only in IDLE.
REQ-014 SHALL, on req_valid & req_ready, register the request and go to TAG; req_valid is ignored in every other state.
REQ-015 SHALL, in TAG (phase 1), compare req_tag against all WAYS tags of the indexed set; hit = match & valid; then go to DATA on hit, else to victim selection.
REQ-016 SHALL, in DATA (phase 2) on a read hit, pulse rsp_valid with rsp_hit=1 and rsp_rdata = addressed byte; rsp_valid is asserted in the 2nd cycle after the accept edge.
REQ-017 SHALL, in DATA on a write hit, write req_wbyte to the addressed byte, set dirty, and pulse rsp_valid with rsp_hit=1 and rsp_rdata=0.
REQ-018 SHALL select the victim as the lowest-index invalid way if any exists; otherwise the lowest-index way with age 0.
REQ-019 SHALL, if the victim is valid & dirty, enter WB and drive mem_req_valid=1, we=1, addr={victim tag,index}, wdata=victim line until mem_req_ready, then enter FILL_REQ; otherwise enter FILL_REQ directly.
REQ-020 SHALL, in FILL_REQ, drive mem_req_valid=1, we=0, addr={req_tag,index} until mem_req_ready, then enter FILL_WAIT.
REQ-021 SHALL hold mem_req_addr, mem_req_we and mem_wdata stable while mem_req_valid=1 and mem_req_ready=0.
REQ-022 SHALL, in FILL_WAIT on mem_rsp_valid, install mem_rsp_data with tag=req_tag, valid=1 and dirty=0, apply req_wbyte and set dirty=1 if the request is a write (write-allocate), then enter RESP.
REQ-023 SHALL, in RESP, pulse rsp_valid with rsp_hit=0 and rsp_rdata = filled byte on read or 0 on write, then return to IDLE.
REQ-024 SHALL ignore mem_rsp_valid outside FILL_WAIT.
REQ-025 SHALL keep a WAY_W-bit age per line; the ages of a set always form a permutation of 0..WAYS-1.
REQ-026 SHALL, on install into way v, decrement every way in the set with age > age(v) and set age(v) = WAYS-1.
REQ-027 SHALL, when REPL=1, apply the same update as REQ-026 to the hit way on every hit; when REPL=0, leave ages unchanged on hits.
REQ-028 SHALL not back-pressure rsp_valid; the response is a single pulse.

Reset
REQ-029 SHALL, when reset=0 at a clk edge, clear all valid and dirty bits, set the age of way w in every set to w, and enter IDLE.
REQ-030 SHALL drive the following values on the cycle after reset: req_ready=1, rsp_valid=0, rsp_hit=0, rsp_rdata=0, mem_req_valid=0, mem_req_we=0, mem_req_addr=0 and mem_wdata=0.
REQ-031 SHALL, on reset mid-transaction in any state, abandon the transaction without a response; any in-flight mem_rsp_valid is then ignored.

Verification
REQ-032 Cold read of tag 0x123, index 1, offset 3 -> mem fill request with addr {0x123,2'b01} and no WB; fill with byte 3 = 0xA5 -> rsp hit=0, rdata=0xA5; repeated read -> hit=1, rdata=0xA5 two cycles after accept.
REQ-033 Write hit of 0x3C at offset 0 -> rsp hit=1, rdata=0x00; subsequent read -> rdata=0x3C; the line is dirty.
REQ-034 REPL=0: fill set 2 with tags 0..7, write tag 0, then miss tag 8 -> WB of {0,2'b10} with the written line, then fill of {8,2'b10} into way 0.
REQ-035 REPL=1: fill set 0 with tags 0..7, read tag 0 (hit), then miss tag 8 -> the victim is tag 1's way and no WB occurs.
REQ-036 Hold mem_req_ready=0 for 5 cycles -> mem_req_valid, addr and wdata stay stable, req_ready=0, and req_valid pulses produce no response.
REQ-037 Assert reset=0 during FILL_WAIT -> next cycle IDLE with req_ready=1 and mem_req_valid=0; a late mem_rsp_valid is ignored; a re-read of the same tag misses.
